word_combiner: RTL and testbench
================================

# word_combiner

Byte-to-word packer for the splitter datapath. It accepts a stream of 8-bit bytes over a valid/ready handshake and assembles each group of four into one 32-bit word. It presents each finished word on a registered valid/ready output. A word can also close early, either on an end-of-packet marker or after an idle timeout.

## Interface
- `FLUSH_TIMEOUT`, default 0: consecutive idle cycles (no accepted byte) after which a partial word is flushed; 0 disables the timeout.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `in_data` input 8: byte to pack.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: combiner accepts a byte this cycle.
- `in_last` input 1: accepted byte closes the current word.
- `out_data` output 32: assembled word.
- `out_valid` output 1: `out_data` holds a word.
- `out_ready` input 1: consumer takes `out_data` this cycle.
- `out_bytes` output 3: count of valid bytes in `out_data`, range 1..4.

## Operation
- **Byte transfer.** A byte is accepted on a cycle where `in_valid && in_ready`.
- **`in_ready` rule.** `in_ready = !reset && (!out_valid || out_ready)`. It is combinational from `out_ready`.
- **Fill FSM.** States are EMPTY, FILL1, FILL2, FILL3, named by bytes held. Each accepted byte advances one state.
- **Completion.** A word completes when any of these occurs:
  - the byte accepted in FILL3 is taken;
  - an accepted byte has `in_last` = 1;
  - a timeout flush fires.
- **On completion.**
  - The assembled word is copied to `out_data` with the unfilled bytes zeroed.
  - `out_bytes` is set to the held count.
  - `out_valid` is set to 1.
  - The FSM returns to EMPTY and the assembly register clears.
- **Byte placement (default).** Byte k (k = 0..3, in arrival order) goes to bits [8k+7:8k]. The first byte lands in [7:0].
- **Output transfer.** A word transfers on `out_valid && out_ready`. If no new word completes that cycle, `out_valid` drops to 0 the next cycle.
- **Simultaneous completion and output handshake.** The new word replaces the old one and `out_valid` stays 1.
- **`in_last` in EMPTY.** Produces a one-byte word, `out_bytes` = 1.
- **Timeout counter.**
  - Active only when `FLUSH_TIMEOUT` > 0.
  - Counts cycles while the FSM is not in EMPTY and no byte is accepted. It resets to 0 on any accepted byte or whenever the FSM is in EMPTY.
  - When the count reaches `FLUSH_TIMEOUT` and the output slot is free (`!out_valid || out_ready`), the partial word is flushed.
  - If the output slot is not free, the flush waits, holding the count, until it is.
- **Bubble-free streaming.** There are no bubbles between words, so sustained throughput is 1 byte per cycle when `out_ready` is held high.

## Timing
- **Reset values** (`reset` sampled high at a rising edge):
  - `out_data` = 0, `out_valid` = 0, `out_bytes` = 0;
  - FSM = EMPTY, assembly register = 0, timeout counter = 0;
  - `in_ready` = 0 while `reset` is high.
- **Latency.** `out_valid` rises on the edge that accepts the completing byte, so it is visible the cycle after that handshake.
- **Timeout flush.** `out_valid` rises on the edge where the count equals `FLUSH_TIMEOUT`.
- **Reset mid-word.** The partial word is discarded and is never emitted.
- **Reset with `out_valid` high.** The pending word is dropped.
- **Output stability.** `out_data` and `out_bytes` hold stable while `out_valid && !out_ready`.
- **Input while stalled.** `in_data`/`in_last` are ignored when `in_ready` = 0, and the FSM does not advance.

## Configuration
- **`COMBINER_BIG_ENDIAN_EN` defined:** byte k goes to bits [31-8k:24-8k], so the first byte lands in [31:24].
  - A partial word is left-aligned, with the low unfilled bytes zeroed.
  - `out_bytes` and all handshake behaviour are unchanged.
- **`COMBINER_BIG_ENDIAN_EN` undefined:** little-endian placement as described in Operation.

## Test plan
- **Full word, little-endian.** Reset, then send 0x11, 0x22, 0x33, 0x44 on consecutive cycles with `out_ready` = 1. Required: `out_data` = 0x44332211, `out_bytes` = 4, `out_valid` high for exactly 1 cycle, starting the cycle after the 0x44 handshake.
- **Early close.** Send 0xAA, then 0xBB with `in_last` = 1. Required: `out_data` = 0x0000BBAA, `out_bytes` = 2.
  - With `COMBINER_BIG_ENDIAN_EN`, the same stimulus gives `out_data` = 0xAABB0000.
- **Backpressure.** Hold `out_ready` = 0 after the first word completes. Required:
  - `in_ready` = 0;
  - `out_data` stays 0x44332211 with bytes withheld;
  - raising `out_ready` lets the next 4 bytes stream with no lost or duplicated byte.
- **Back-to-back words.** Stream 8 bytes 0x01..0x08 with `out_ready` = 1. Required: words 0x04030201 then 0x08070605 on consecutive handshakes, with no idle input cycle.
- **Timeout.** With `FLUSH_TIMEOUT` = 3, send 0x5A, then idle with `in_valid` = 0. Required: `out_data` = 0x0000005A, `out_bytes` = 1, `out_valid` visible 3 cycles after the accepting edge.
- **Reset mid-word.** Send 0x11 and 0x22, assert `reset` for 1 cycle, then send 0x33, 0x44, 0x55, 0x66. Required: only 0x66554433 is emitted.

Source files
------------

// File: rtl/word_combiner.sv
// -----------------------------------------------------------------------------
// word_combiner
//
// Packs a stream of 8-bit bytes into 32-bit words. Four accepted bytes make a
// full word. A word can close early when the accepting byte carries in_last,
// or when the input has been idle for FLUSH_TIMEOUT cycles. Finished words are
// held in a registered output slot with a valid/ready handshake.
//
// Parameters
//   FLUSH_TIMEOUT  idle cycles before a partial word is flushed (0 = never)
//
// Compile-time option
//   COMBINER_BIG_ENDIAN_EN  when defined, the first byte of a word lands in
//                           [31:24] and partial words are left-aligned.
//                           When undefined, the first byte lands in [7:0].
//
// Ports
//   clk        clock, rising edge
//   reset      synchronous active-high reset
//   in_data    byte to pack
//   in_valid   in_data is valid
//   in_ready   combiner can take a byte this cycle (combinational from out_ready)
//   in_last    accepted byte closes the current word
//   out_data   assembled word, unfilled bytes zero
//   out_valid  out_data holds a word
//   out_ready  consumer takes out_data this cycle
//   out_bytes  number of valid bytes in out_data (1..4)
// -----------------------------------------------------------------------------
module word_combiner #(
  parameter int FLUSH_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  out_bytes
);

  // State names give the number of bytes currently held.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL1 = 2'd1,
    FILL2 = 2'd2,
    FILL3 = 2'd3
  } fill_state_t;

  fill_state_t state_q, state_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic [2:0]  out_bytes_q, out_bytes_d;

  logic        slot_free;
  logic        accept;
  logic        flush;
  logic [1:0]  lane;
  logic [2:0]  held;
  logic [31:0] merged_word;

  // The output slot can take a new word if it is empty or being drained now.
  // Every completion is gated by this, so a pending word is never overwritten.
  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = !reset && slot_free;
  assign accept    = in_valid && in_ready;

  // The state encoding equals the number of bytes already held, which is also
  // the arrival index of the byte being accepted now.
  assign held = {1'b0, state_q};

`ifdef COMBINER_BIG_ENDIAN_EN
  assign lane = 2'd3 - state_q;
`else
  assign lane = state_q;
`endif

  // Assembly register with the incoming byte dropped into its lane. Lanes not
  // yet written are still zero because the register clears after every word.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign merged_word[8*gi +: 8] = (lane == 2'(gi)) ? in_data : asm_q[8*gi +: 8];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Idle-timeout flush
  // ---------------------------------------------------------------------------
  generate
    if (FLUSH_TIMEOUT > 0) begin : g_timeout
      localparam int CNT_W = $clog2(FLUSH_TIMEOUT + 1);
      localparam logic [CNT_W-1:0] LIMIT = CNT_W'(FLUSH_TIMEOUT);

      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [CNT_W-1:0] cnt_inc;
      logic             idle;

      // Idle means a partial word is held and nothing was taken this cycle.
      // The flush fires on the edge where the count would reach LIMIT; if the
      // output slot is busy the count parks at LIMIT until the slot frees.
      always_comb begin
        idle    = (state_q != EMPTY) && !accept;
        cnt_inc = (cnt_q == LIMIT) ? LIMIT : cnt_q + 1'b1;
        cnt_d   = '0;
        flush   = 1'b0;
        if (idle) begin
          if ((cnt_inc == LIMIT) && slot_free) begin
            flush = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end else begin : g_no_timeout
      assign flush = 1'b0;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Fill FSM and output slot
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    asm_d       = asm_q;
    out_data_d  = out_data_q;
    out_bytes_d = out_bytes_q;
    // A word handed over this cycle leaves the slot empty unless a new word
    // lands in it on the same edge (handled below).
    out_valid_d = out_valid_q && !out_ready;

    if (accept) begin
      if ((state_q == FILL3) || in_last) begin
        out_data_d  = merged_word;
        out_bytes_d = held + 3'd1;
        out_valid_d = 1'b1;
        state_d     = EMPTY;
        asm_d       = '0;
      end else begin
        asm_d = merged_word;
        case (state_q)
          EMPTY:   state_d = FILL1;
          FILL1:   state_d = FILL2;
          default: state_d = FILL3;
        endcase
      end
    end else if (flush) begin
      out_data_d  = asm_q;
      out_bytes_d = held;
      out_valid_d = 1'b1;
      state_d     = EMPTY;
      asm_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      asm_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_bytes_q <= '0;
    end else begin
      state_q     <= state_d;
      asm_q       <= asm_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_bytes_q <= out_bytes_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_bytes = out_bytes_q;

endmodule

// File: tb/tb_word_combiner.sv
// -----------------------------------------------------------------------------
// tb_word_combiner
//
// Self-checking bench for word_combiner with FLUSH_TIMEOUT = 3. A reference
// model built on a byte queue tracks the expected output slot every cycle;
// directed scenarios additionally compare against literal expected words.
// -----------------------------------------------------------------------------
module tb_word_combiner;

  localparam int TO = 3;

`ifdef COMBINER_BIG_ENDIAN_EN
  localparam logic [31:0] W_FULL  = 32'h11223344;
  localparam logic [31:0] W_EARLY = 32'hAABB0000;
  localparam logic [31:0] W_ONE   = 32'h7E000000;
  localparam logic [31:0] W_BP2   = 32'h55667788;
  localparam logic [31:0] W_B2B0  = 32'h01020304;
  localparam logic [31:0] W_B2B1  = 32'h05060708;
  localparam logic [31:0] W_TO    = 32'h5A000000;
  localparam logic [31:0] W_RST   = 32'h33445566;
`else
  localparam logic [31:0] W_FULL  = 32'h44332211;
  localparam logic [31:0] W_EARLY = 32'h0000BBAA;
  localparam logic [31:0] W_ONE   = 32'h0000007E;
  localparam logic [31:0] W_BP2   = 32'h88776655;
  localparam logic [31:0] W_B2B0  = 32'h04030201;
  localparam logic [31:0] W_B2B1  = 32'h08070605;
  localparam logic [31:0] W_TO    = 32'h0000005A;
  localparam logic [31:0] W_RST   = 32'h66554433;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic [2:0]  out_bytes;

  int checks = 0;
  int errors = 0;

  // Reference model state
  byte unsigned pend[$];
  int           idle_cnt = 0;
  logic         m_valid = 1'b0;
  logic [31:0]  m_data = '0;
  logic [2:0]   m_bytes = '0;
  logic         m_ready = 1'b0;
  logic         s_in_ready = 1'b0;
  int           cyc = 0;

  // Words seen leaving the DUT: {out_bytes, out_data} and the cycle taken
  logic [34:0]  got[$];
  int           got_cyc[$];

  word_combiner #(.FLUSH_TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bytes (out_bytes)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pack_pending();
    logic [31:0] w;
    int          sh;
    w = '0;
    for (int k = 0; k < pend.size(); k++) begin
`ifdef COMBINER_BIG_ENDIAN_EN
      sh = 24 - 8 * k;
`else
      sh = 8 * k;
`endif
      w = w | (32'(pend[k]) << sh);
    end
    return w;
  endfunction

  // Advance one clock: sample pre-edge handshake, step the model, settle.
  task automatic tick();
    logic acc;
    logic slot;
    logic emitted;
    #1;
    s_in_ready = in_ready;
    m_ready    = !reset && (!m_valid || out_ready);
    acc        = in_valid && m_ready;
    slot       = !m_valid || out_ready;
    if (out_valid && out_ready && !reset) begin
      got.push_back({out_bytes, out_data});
      got_cyc.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    emitted = 1'b0;
    if (reset) begin
      pend.delete();
      idle_cnt = 0;
      m_valid  = 1'b0;
      m_data   = '0;
      m_bytes  = '0;
    end else begin
      if (acc) begin
        pend.push_back(in_data);
        idle_cnt = 0;
        if (pend.size() == 4 || in_last) begin
          m_data  = pack_pending();
          m_bytes = 3'(pend.size());
          m_valid = 1'b1;
          pend.delete();
          emitted = 1'b1;
        end
      end else if (pend.size() > 0) begin
        idle_cnt = (idle_cnt + 1 > TO) ? TO : idle_cnt + 1;
        if (idle_cnt == TO && slot) begin
          m_data   = pack_pending();
          m_bytes  = 3'(pend.size());
          m_valid  = 1'b1;
          pend.delete();
          idle_cnt = 0;
          emitted  = 1'b1;
        end
      end else begin
        idle_cnt = 0;
      end
      if (!emitted && m_valid && out_ready) m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    got.delete();
    got_cyc.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_data = 8'hC3; in_last = 1'b1; out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (s_in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 0", s_in_ready);
    end
    checks++;
    if ({out_valid, out_bytes, out_data} !== 36'h0) begin
      errors++; $display("FAIL reset_outputs: got valid=%b bytes=%0d data=%h expected all zero",
                         out_valid, out_bytes, out_data);
    end
    reset = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_full_word();
    logic [7:0] seq [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = seq[i]; in_last = 1'b0;
      tick();
      checks++;
      if ({s_in_ready, out_valid, out_bytes, out_data} !== {1'b1, m_valid, m_bytes, m_data}) begin
        errors++; $display("FAIL full_word_model: got rdy=%b v=%b n=%0d d=%h expected rdy=1 v=%b n=%0d d=%h",
                           s_in_ready, out_valid, out_bytes, out_data, m_valid, m_bytes, m_data);
      end
    end
    checks++;
    if ({out_valid, out_bytes, out_data} !== {1'b1, 3'd4, W_FULL}) begin
      errors++; $display("FAIL full_word: got v=%b n=%0d d=%h expected v=1 n=4 d=%h",
                         out_valid, out_bytes, out_data, W_FULL);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL full_word_one_cycle: got out_valid=%b expected 0", out_valid);
    end
    $display("test_full_word done: word %h", W_FULL);
  endtask

  task automatic test_early_close();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'hAA; in_last = 1'b0;
    tick();
    in_data = 8'hBB; in_last = 1'b1;
    tick();
    checks++;
    if ({out_valid, out_bytes, out_data} !== {1'b1, 3'd2, W_EARLY}) begin
      errors++; $display("FAIL early_close: got v=%b n=%0d d=%h expected v=1 n=2 d=%h",
                         out_valid, out_bytes, out_data, W_EARLY);
    end
    // in_last on the first byte of a word gives a one-byte word
    in_data = 8'h7E; in_last = 1'b1;
    tick();
    checks++;
    if ({out_valid, out_bytes, out_data} !== {1'b1, 3'd1, W_ONE}) begin
      errors++; $display("FAIL last_in_empty: got v=%b n=%0d d=%h expected v=1 n=1 d=%h",
                         out_valid, out_bytes, out_data, W_ONE);
    end
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    $display("test_early_close done");
  endtask

  task automatic test_backpressure();
    logic [7:0] seq1 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] seq2 [4] = '{8'h55, 8'h66, 8'h77, 8'h88};
    int idx;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = seq1[i]; in_last = 1'b0;
      tick();
    end
    in_data = 8'h55;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({s_in_ready, out_valid, out_bytes, out_data} !== {1'b0, 1'b1, 3'd4, W_FULL}) begin
        errors++; $display("FAIL backpressure_hold: got rdy=%b v=%b n=%0d d=%h expected rdy=0 v=1 n=4 d=%h",
                           s_in_ready, out_valid, out_bytes, out_data, W_FULL);
      end
    end
    out_ready = 1'b1;
    idx = 0;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      in_valid = 1'b1; in_data = seq2[idx];
      tick();
      if (s_in_ready) idx++;
      checks++;
      if ({out_valid, out_bytes, out_data} !== {m_valid, m_bytes, m_data}) begin
        errors++; $display("FAIL backpressure_model: got v=%b n=%0d d=%h expected v=%b n=%0d d=%h",
                           out_valid, out_bytes, out_data, m_valid, m_bytes, m_data);
      end
    end
    checks++;
    if (idx != 4) begin
      errors++; $display("FAIL backpressure_stream_timeout: got %0d bytes accepted expected 4", idx);
    end
    in_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (got.size() != 2 || got[0] !== {3'd4, W_FULL} || got[1] !== {3'd4, W_BP2}) begin
      errors++; $display("FAIL backpressure_words: got %0d words first=%h expected 2 words %h %h",
                         got.size(), (got.size() > 0) ? got[0] : 35'h0, {3'd4, W_FULL}, {3'd4, W_BP2});
    end
    $display("test_backpressure done: %0d words", got.size());
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 8'(i + 1); in_last = 1'b0;
      tick();
      checks++;
      if (s_in_ready !== 1'b1) begin
        errors++; $display("FAIL back_to_back_ready: byte %0d got in_ready=%b expected 1", i, s_in_ready);
      end
    end
    in_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (got.size() != 2 || got[0] !== {3'd4, W_B2B0} || got[1] !== {3'd4, W_B2B1}) begin
      errors++; $display("FAIL back_to_back_words: got %0d words first=%h expected %h %h",
                         got.size(), (got.size() > 0) ? got[0] : 35'h0, {3'd4, W_B2B0}, {3'd4, W_B2B1});
    end else begin
      checks++;
      if (got_cyc[1] - got_cyc[0] != 4) begin
        errors++; $display("FAIL back_to_back_spacing: got %0d cycles expected 4", got_cyc[1] - got_cyc[0]);
      end
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_timeout();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h5A; in_last = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= TO; i++) begin
      tick();
      if (i < TO) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++; $display("FAIL timeout_early: cycle %0d got out_valid=%b expected 0", i, out_valid);
        end
      end
    end
    checks++;
    if ({out_valid, out_bytes, out_data} !== {1'b1, 3'd1, W_TO}) begin
      errors++; $display("FAIL timeout_flush: got v=%b n=%0d d=%h expected v=1 n=1 d=%h",
                         out_valid, out_bytes, out_data, W_TO);
    end
    tick();
    $display("test_timeout done");
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] seq [4] = '{8'h33, 8'h44, 8'h55, 8'h66};
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h11; tick();
    in_data = 8'h22; tick();
    reset = 1'b1; in_valid = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = seq[i];
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < TO + 3; i++) tick();
    checks++;
    if (got.size() != 1 || got[0] !== {3'd4, W_RST}) begin
      errors++; $display("FAIL reset_mid_word: got %0d words first=%h expected 1 word %h",
                         got.size(), (got.size() > 0) ? got[0] : 35'h0, {3'd4, W_RST});
    end
    $display("test_reset_mid_word done");
  endtask

  task automatic test_random();
    int bad = 0;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      reset     = ($urandom_range(0, 249) == 0);
      in_valid  = ($urandom_range(0, 9) < 6);
      in_data   = 8'($urandom);
      in_last   = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      checks++;
      if ({s_in_ready, out_valid, out_bytes, out_data} !== {m_ready, m_valid, m_bytes, m_data}) begin
        errors++; bad++;
        if (bad <= 10)
          $display("FAIL random_model: cycle %0d got rdy=%b v=%b n=%0d d=%h expected rdy=%b v=%b n=%0d d=%h",
                   i, s_in_ready, out_valid, out_bytes, out_data, m_ready, m_valid, m_bytes, m_data);
      end
    end
    reset = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    $display("test_random done: %0d cycles", 800);
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_early_close();
    test_backpressure();
    test_back_to_back();
    test_timeout();
    test_reset_mid_word();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
